seq_slice_adder: RTL and testbench
==================================

// Module: seq_slice_adder
// PURPOSE
//   Iterative WIDTH-bit adder. One SLICE-bit ripple slice is reused over WIDTH/SLICE cycles.
//   The carry is registered between slices.
//   Sits beside the 8-bit combinational adder as the wide, area-lean adder for the multiplier datapath.
//   Valid/ready handshake on input and output; one operation in flight.
// PARAMETERS
//   WIDTH  16  operand/result width; must be a multiple of SLICE
//   SLICE  4   bits added per cycle; NSLICE = WIDTH/SLICE (>=1) cycles per operation
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in to bit 0
//   sub        in   1      subtract request (present only with SEQ_ADDER_SUB_EN)
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, (a + b + cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   overflow   out  1      signed overflow = carry into MSB XOR cout
// BEHAVIOUR
//   Reset (async, any state):
//     - state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; overflow=0
//     - slice counter=0; carry reg=0; any operation in progress is discarded
//   FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1.
//     - in_valid&&in_ready at edge E0: latch a, b, carry<=cin; k<=0; go to RUN.
//   RUN: in_ready=0, out_valid=0.
//     - Edge k+1 (k=0..NSLICE-1): bits [k*SLICE +: SLICE] <= a_k + b_k + carry; carry <= slice carry-out.
//     - On the last slice, also latch cout and overflow (carry into MSB captured from the last slice's ripple); go to DONE.
//     - Latency: out_valid rises NSLICE edges after E0. WIDTH=16, SLICE=4 -> 4 cycles.
//   DONE: out_valid=1; sum/cout/overflow held stable.
//     - out_ready low: hold indefinitely.
//     - out_valid&&out_ready at an edge: go to IDLE. in_ready rises the following cycle (no same-cycle restart).
//   Inputs a/b/cin/sub are ignored outside the IDLE accept edge; changing them mid-op has no effect.
//   sum/cout/overflow are defined only while out_valid=1 (internally they update per slice).
//   NSLICE=1 degenerates to a single RUN cycle; the counter must not wrap or skip DONE.
// CONFIGURATION
//   SEQ_ADDER_SUB_EN defined:
//     - Port sub exists; latched at accept.
//     - sub=1 computes a + ~b + 1, ignoring cin. cout=1 means no borrow; overflow is the signed subtract overflow.
//     - sub=0 behaves as add.
//   SEQ_ADDER_SUB_EN undefined: no sub port; add only.
// TESTING  (WIDTH=16, SLICE=4 unless noted)
//   1. Reset:
//      - rst_n low -> in_ready=1, out_valid=0, sum=0, cout=0, overflow=0.
//   2. a=16'h1234, b=16'h0FCC, cin=0:
//      - out_valid exactly 4 cycles after accept; sum=16'h2200, cout=0, overflow=0.
//   3. Full carry ripple across all slices, a=16'hFFFF, b=16'h0000, cin=1:
//      - sum=16'h0000, cout=1, overflow=0.
//   4. Signed overflow, a=16'h7FFF, b=16'h0001, cin=0:
//      - sum=16'h8000, cout=0, overflow=1.
//   5. Backpressure, out_ready=0 for 10 cycles in DONE:
//      - out_valid stays 1, sum stable, in_ready=0.
//      - After out_ready=1 handshake: IDLE next cycle, then a back-to-back second op is correct.
//   6. Reset mid-op, rst_n pulsed after slice 2:
//      - Outputs at reset values immediately.
//      - Next op a=16'h0001, b=16'h0001 -> sum=16'h0002.
//      - With SEQ_ADDER_SUB_EN: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0.

Source files
------------

// File: rtl/seq_slice_adder.sv
// ============================================================================
// Module      : seq_slice_adder
// Description : Iterative WIDTH-bit adder reusing one SLICE-bit ripple slice
//               over WIDTH/SLICE cycles, with valid/ready handshakes.
//               Optional subtract mode enabled by macro SEQ_ADDER_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_slice_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] C_K_LAST = CW'(NSLICE - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic             carry_q,    carry_d;
    logic [CW-1:0]    k_q,        k_d;
    logic [WIDTH-1:0] sum_q,      sum_d;
    logic             cout_q,     cout_d;
    logic             overflow_q, overflow_d;

    logic             w_sub;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE:0]   w_slice_res;
    logic             w_msb_cin;

`ifdef SEQ_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    always_comb begin
        w_a_slice   = a_q[k_q*SLICE +: SLICE];
        w_b_slice   = b_q[k_q*SLICE +: SLICE];
        w_slice_res = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE{1'b0}}, carry_q};
        // Carry into the top bit of this slice, recovered from the sum bit
        w_msb_cin   = w_slice_res[SLICE-1] ^ w_a_slice[SLICE-1] ^ w_b_slice[SLICE-1];
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        k_d        = k_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;

        case (state_q)
            C_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction is a + ~b + 1; cin is ignored in that mode
                    b_d     = w_sub ? ~b : b;
                    carry_d = w_sub ? 1'b1 : cin;
                    k_d     = '0;
                    state_d = C_RUN;
                end
            end
            C_RUN: begin
                sum_d[k_q*SLICE +: SLICE] = w_slice_res[SLICE-1:0];
                carry_d = w_slice_res[SLICE];
                if (k_q == C_K_LAST) begin
                    cout_d     = w_slice_res[SLICE];
                    overflow_d = w_msb_cin ^ w_slice_res[SLICE];
                    state_d    = C_DONE;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            C_DONE: begin
                if (out_ready) begin
                    state_d = C_IDLE;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= C_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            k_q        <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            k_q        <= k_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == C_IDLE);
    assign out_valid = (state_q == C_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_slice_adder.sv
// ============================================================================
// Module      : tb_seq_slice_adder
// Description : Scoreboard bench for seq_slice_adder (WIDTH=16, SLICE=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_slice_adder;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    seq_slice_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SEQ_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain wide arithmetic, signed overflow from operand/result signs
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mcin, input logic msub);
        exp_t             e;
        logic [WIDTH-1:0] be;
        logic             ce;
        logic [WIDTH:0]   full;
        be    = msub ? ~mb : mb;
        ce    = msub ? 1'b1 : mcin;
        full  = {1'b0, ma} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (ma[WIDTH-1] == be[WIDTH-1]) && (e.sum[WIDTH-1] != ma[WIDTH-1]);
        return e;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                          input logic tcin, input logic tsub, input int hold);
        int               lat;
        exp_t             e;
        logic [WIDTH-1:0] held;
        wait_ready();
        in_valid = 1'b1;
        a   = ta;
        b   = tb_b;
        cin = tcin;
        sub = tsub;
        exp_q.push_back(model(ta, tb_b, tcin, tsub));
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble operands mid-op; the DUT must ignore them
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(WIDTH / SLICE));
        held = sum;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_sum", {16'd0, sum}, {16'd0, held});
            check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        e = exp_q.pop_front();
        check_eq("sum", {16'd0, sum}, {16'd0, e.sum});
        check_eq("cout", {31'd0, cout}, {31'd0, e.cout});
        check_eq("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check_eq("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_sum"}, {16'd0, sum}, 32'd0);
        check_eq({tag, "_cout"}, {31'd0, cout}, 32'd0);
        check_eq({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h0FCC, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
        // Backpressure then immediate back-to-back op
        run_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 10);
        run_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 0);

        // Reset after two slices of an in-flight op
        wait_ready();
        in_valid = 1'b1;
        a   = 16'hFFFF;
        b   = 16'hFFFF;
        cin = 1'b1;
        sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

`ifdef SEQ_ADDER_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 2);
`endif

        for (int i = 0; i < 8; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, i % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
